univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/usr_pkg.sv | 40 ++++
 rtl/univ_shift_reg_if.sv | 27 ++
 rtl/usr_step.sv | 32 +++
 rtl/univ_shift_reg.sv | 112 +++++++++++
 tb/tb_univ_shift_reg.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// FSM state encoding and the mode legality check.
// Optional feature macro: USR_ARITH_EN (enables mode 110 as arithmetic shift right).
package usr_pkg;

    // Operation codes presented on the mode input
    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_ILL  = 3'b111
    } usr_mode_e;

    // Operation sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } usr_state_e;

    // A mode is accepted unless it is the reserved code, or the arithmetic
    // shift code in a build that leaves arithmetic shifting out.
    function automatic logic usr_mode_legal(input logic [2:0] mode);
        logic legal_s;
        legal_s = 1'b1;
        case (mode)
            3'b111:  legal_s = 1'b0;
`ifndef USR_ARITH_EN
            3'b110:  legal_s = 1'b0;
`endif
            default: legal_s = 1'b1;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Request/response bundle of the universal shift register.
// Optional feature macro: USR_ARITH_EN (no effect on this interface).
interface univ_shift_reg_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH) + 1
);
    logic                   start;
    logic [2:0]             mode;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0]  data_in;
    logic                   Left_in;
    logic                   Right_in;
    logic [DATA_WIDTH-1:0]  data_out;
    logic                   busy;
    logic                   done;
    logic                   err;

    modport master (
        output start, mode, shamt, data_in, Left_in, Right_in,
        input  data_out, busy, done, err
    );

    modport slave (
        input  start, mode, shamt, data_in, Left_in, Right_in,
        output data_out, busy, done, err
    );
endinterface

// File: rtl/usr_step.sv
// One-step next-value logic for the shift register. Purely combinational:
// given the captured mode, the current contents and the live serial bits it
// produces what the register would hold after a single shift/rotate step.
// Optional feature macro: USR_ARITH_EN (adds the arithmetic shift right step).
module usr_step
    import usr_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  usr_mode_e             mode,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  left_in,
    input  logic                  right_in,
    output logic [DATA_WIDTH-1:0] next_data
);

    // Select the single-bit step for the active mode; anything else holds
    always_comb begin
        next_data = data;
        case (mode)
            MODE_SHL: next_data = {data[DATA_WIDTH-2:0], right_in};
            MODE_SHR: next_data = {left_in, data[DATA_WIDTH-1:1]};
            MODE_ROL: next_data = {data[DATA_WIDTH-2:0], data[DATA_WIDTH-1]};
            MODE_ROR: next_data = {data[0], data[DATA_WIDTH-1:1]};
`ifdef USR_ARITH_EN
            MODE_ASR: next_data = {data[DATA_WIDTH-1], data[DATA_WIDTH-1:1]};
`endif
            default:  next_data = data;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: loads, holds, shifts, rotates (and optionally
// arithmetic-shifts) its contents under control of a small IDLE/RUN/DONE
// sequencer. A multi-bit shift is performed one bit per clock, counting a
// captured step count down to zero. All outputs are registered.
// Optional feature macro: USR_ARITH_EN (mode 110 = arithmetic shift right;
// when undefined, mode 110 is rejected like the reserved code).
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
    input  logic           clk,
    input  logic           n_rst,
    univ_shift_reg_if.slave bus
);

    localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};

    usr_state_e             state_r;
    usr_mode_e              mode_r;
    logic [SHAMT_WIDTH-1:0] cnt_r;
    logic [DATA_WIDTH-1:0]  data_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   err_r;
    logic [DATA_WIDTH-1:0]  step_s;

    usr_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .mode      (mode_r),
        .data      (data_r),
        .left_in   (bus.Left_in),
        .right_in  (bus.Right_in),
        .next_data (step_s)
    );

    // Sequencer: accept a request in IDLE, step once per cycle in RUN, pulse done from DONE
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_HOLD;
            cnt_r   <= '0;
            data_r  <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    err_r  <= 1'b0;
                    if (bus.start) begin
                        if (usr_mode_legal(bus.mode)) begin
                            mode_r  <= usr_mode_e'(bus.mode);
                            busy_r  <= 1'b1;
                            state_r <= ST_RUN;
                            // LOAD and HOLD finish after one RUN cycle, so no steps are counted
                            if (bus.mode == MODE_LOAD) begin
                                data_r <= bus.data_in;
                                cnt_r  <= '0;
                            end else if (bus.mode == MODE_HOLD) begin
                                cnt_r  <= '0;
                            end else begin
                                cnt_r  <= bus.shamt;
                            end
                        end else begin
                            // Rejected request: flag it and stay put with contents untouched
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    err_r <= 1'b0;
                    if (cnt_r == '0) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        data_r <= step_s;
                        cnt_r  <= cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out = data_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (DATA_WIDTH=8). Requests push their
// expected completion into a scoreboard; a monitor pops and checks whenever
// done or err pulses. Expected values come from a queue/arithmetic model.
// Optional feature macro: USR_ARITH_EN (bench follows the same setting).
module tb_univ_shift_reg;
    import usr_pkg::*;

    localparam int W  = 8;
    localparam int SW = $clog2(W) + 1;

    typedef struct {
        bit           is_err;
        logic [W-1:0] data;
        int           issue;
        int           lat;
        int           busy_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_cnt = 0;
    exp_t sb[$];
    logic [W-1:0] model_q = '0;

    univ_shift_reg_if #(.DATA_WIDTH(W), .SHAMT_WIDTH(SW)) bus ();

    univ_shift_reg #(.DATA_WIDTH(W), .SHAMT_WIDTH(SW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: result of a whole operation from the rules, not step by step
    function automatic logic [W-1:0] ref_model(input logic [2:0] m, input int n,
                                               input logic [W-1:0] cur, input logic [W-1:0] din,
                                               input bit lb[$], input bit rb[$]);
        bit q[$];
        logic [W-1:0]   r;
        logic [2*W-1:0] d;
        r = cur;
        case (m)
            3'b001: r = din;
            3'b010: begin
                // bit stream: old contents then every bit fed in at the LSB; keep the newest W
                for (int i = W - 1; i >= 0; i--) q.push_back(cur[i]);
                foreach (rb[i]) q.push_back(rb[i]);
                for (int i = 0; i < W; i++) r[W-1-i] = q[q.size() - W + i];
            end
            3'b011: begin
                for (int i = W - 1; i >= 0; i--) q.push_back(cur[i]);
                foreach (lb[i]) q.push_front(lb[i]);
                for (int i = 0; i < W; i++) r[W-1-i] = q[i];
            end
            3'b100: begin
                d = {cur, cur} << (n % W);
                r = d[2*W-1:W];
            end
            3'b101: begin
                d = {cur, cur} >> (n % W);
                r = d[W-1:0];
            end
            3'b110: r = $signed(cur) >>> n;
            default: r = cur;
        endcase
        return r;
    endfunction

    // Issue one request, drive serial bits for every step, return when the block is idle again
    task automatic run_op(input logic [2:0] m, input int n, input logic [W-1:0] din,
                          input bit rnd_serial, input bit fixed_bit, input bit restart);
        bit   lb[$];
        bit   rb[$];
        bit   legal;
        int   lat;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            lb.push_back(rnd_serial ? bit'($urandom_range(0, 1)) : fixed_bit);
            rb.push_back(rnd_serial ? bit'($urandom_range(0, 1)) : fixed_bit);
        end
        legal = (m != 3'b111);
`ifndef USR_ARITH_EN
        if (m == 3'b110) legal = 1'b0;
`endif
        if (!legal)                          lat = 1;
        else if (m == 3'b000 || m == 3'b001) lat = 2;
        else                                 lat = ((n > 1) ? n : 1) + 1;
        e.is_err   = !legal;
        e.data     = legal ? ref_model(m, n, model_q, din, lb, rb) : model_q;
        e.issue    = cyc;
        e.lat      = lat;
        e.busy_cyc = legal ? lat - 1 : 0;
        sb.push_back(e);
        model_q = e.data;

        bus.start    = 1'b1;
        bus.mode     = m;
        bus.shamt    = SW'(n);
        bus.data_in  = din;
        bus.Left_in  = 1'($urandom);
        bus.Right_in = 1'($urandom);
        @(posedge clk); #1;
        for (int c = 1; c <= lat; c++) begin
            bus.start    = legal && restart;
            bus.mode     = restart ? 3'b010 : 3'($urandom);
            bus.shamt    = SW'($urandom);
            bus.data_in  = W'($urandom);
            bus.Left_in  = (c - 1 < n) ? lb[c-1] : 1'($urandom);
            bus.Right_in = (c - 1 < n) ? rb[c-1] : 1'($urandom);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
    endtask

    // Monitor: count busy cycles of the pending request, check each done/err pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (sb.size() != 0 && cyc > sb[0].issue && bus.busy) busy_cnt++;
                if (bus.done || bus.err) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_pulse: got done=%0b err=%0b, expected none (cycle %0d)",
                                 bus.done, bus.err, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("err_flag", 32'(bus.err), 32'(e.is_err));
                        chk("done_flag", 32'(bus.done), 32'(!e.is_err));
                        chk("data_out", 32'(bus.data_out), 32'(e.data));
                        chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                        chk("busy_cycles", 32'(busy_cnt), 32'(e.busy_cyc));
                        chk("busy_at_end", 32'(bus.busy), 32'd0);
                    end
                    busy_cnt = 0;
                end
                if (sb.size() == 0) busy_cnt = 0;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] prev;
        bus.start = 1'b0; bus.mode = 3'b000; bus.shamt = '0; bus.data_in = '0;
        bus.Left_in = 1'b0; bus.Right_in = 1'b0;
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // LOAD, then SHL by 3 feeding ones
        run_op(3'b001, 0, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("load_a5", 32'(bus.data_out), 32'h0000_00A5);
        run_op(3'b010, 3, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("shl3_2f", 32'(bus.data_out), 32'h0000_002F);
        // ROR by more than the width wraps
        run_op(3'b001, 0, 8'h81, 1'b0, 1'b0, 1'b0);
        run_op(3'b101, 9, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("ror9_c0", 32'(bus.data_out), 32'h0000_00C0);
        // Mode 110: arithmetic shift or rejection depending on build
        run_op(3'b001, 0, 8'h90, 1'b0, 1'b0, 1'b0);
        run_op(3'b110, 2, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef USR_ARITH_EN
        chk("asr2_e4", 32'(bus.data_out), 32'h0000_00E4);
`else
        chk("mode110_kept", 32'(bus.data_out), 32'h0000_0090);
`endif
        // shamt=0 with restart pulses during RUN/DONE, then the reserved code
        prev = model_q;
        run_op(3'b010, 0, 8'h3C, 1'b1, 1'b0, 1'b1);
        chk("shamt0_unchanged", 32'(bus.data_out), 32'(prev));
        run_op(3'b111, 4, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("illegal_kept", 32'(bus.data_out), 32'(prev));
        run_op(3'b000, 5, 8'h77, 1'b1, 1'b0, 1'b1);

        // Abort a SHR run with a short reset pulse
        run_op(3'b001, 0, 8'hF3, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1; bus.mode = 3'b011; bus.shamt = SW'(5);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        n_rst = 1'b0;
        #1;
        chk("abort_data", 32'(bus.data_out), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        #1;
        n_rst = 1'b1;
        model_q = '0;
        @(posedge clk); #1;
        run_op(3'b001, 0, 8'h6B, 1'b0, 1'b0, 1'b0);
        chk("load_after_rst", 32'(bus.data_out), 32'h0000_006B);

        // Randomized requests
        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)), W'($urandom),
                   1'b1, 1'b0, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
